// File: rtl/exit_gate_controller.sv
// Exit barrier sequencer and live occupancy counter feeding the entry checker.
// Optional EXIT_COUNT_EN macro builds the saturating cumulative exits_total counter.
`timescale 1ns/1ps
module exit_gate_controller #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CAPACITY     = 7,
    parameter int unsigned OPEN_TIMEOUT = 16,
    parameter int unsigned CLOSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_grant,
    input  logic             exit_req,
    input  logic             car_passed,
    output logic [WIDTH-1:0] occupancy,
    output logic             gate_open,
    output logic             gate_closing,
    output logic             exit_done,
    output logic             exit_error,
    output logic [15:0]      exits_total
);

    localparam int unsigned TMAX = (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPEN    = 2'd1,
        S_CLOSING = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nxt;
    logic [WIDTH-1:0] r_occ;
    logic [WIDTH-1:0] w_occ_nxt;
    logic             w_exit_ok;
    logic             w_exit_err;
    logic             r_gate_open;
    logic             r_gate_closing;
    logic             r_exit_done;
    logic             r_exit_error;

    // State and phase timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Next-state, exit outcome and occupancy update
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_exit_ok   = 1'b0;
        w_exit_err  = 1'b0;
        w_occ_nxt   = r_occ;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (exit_req) begin
                    if (r_occ != '0) begin
                        w_state_nxt = S_OPEN;
                    end else begin
                        w_exit_err = 1'b1;
                    end
                end
            end
            S_OPEN: begin
                w_timer_nxt = r_timer + TW'(1);
                // A pass on the final open cycle still counts as a confirmed exit
                if (car_passed) begin
                    w_state_nxt = S_CLOSING;
                    w_timer_nxt = '0;
                    w_exit_ok   = 1'b1;
                end else if (r_timer == TW'(OPEN_TIMEOUT - 1)) begin
                    w_state_nxt = S_CLOSING;
                    w_timer_nxt = '0;
                    w_exit_err  = 1'b1;
                end
            end
            S_CLOSING: begin
                w_timer_nxt = r_timer + TW'(1);
                if (r_timer == TW'(CLOSE_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase

        // Coincident entry and exit cancel, even when the lot is full
        if (w_exit_ok && entry_grant) begin
            w_occ_nxt = r_occ;
        end else if (w_exit_ok) begin
            if (r_occ != '0) begin
                w_occ_nxt = r_occ - WIDTH'(1);
            end
        end else if (entry_grant && (r_occ < WIDTH'(CAPACITY))) begin
            w_occ_nxt = r_occ + WIDTH'(1);
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ          <= '0;
            r_gate_open    <= 1'b0;
            r_gate_closing <= 1'b0;
            r_exit_done    <= 1'b0;
            r_exit_error   <= 1'b0;
        end else begin
            r_occ          <= w_occ_nxt;
            r_gate_open    <= (w_state_nxt == S_OPEN);
            r_gate_closing <= (w_state_nxt == S_CLOSING);
            r_exit_done    <= w_exit_ok;
            r_exit_error   <= w_exit_err;
        end
    end

    assign occupancy    = r_occ;
    assign gate_open    = r_gate_open;
    assign gate_closing = r_gate_closing;
    assign exit_done    = r_exit_done;
    assign exit_error   = r_exit_error;

`ifdef EXIT_COUNT_EN
    logic [15:0] r_exits_total;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exits_total <= 16'd0;
        end else if (w_exit_ok && (r_exits_total != 16'hFFFF)) begin
            r_exits_total <= r_exits_total + 16'd1;
        end
    end

    assign exits_total = r_exits_total;
`else
    assign exits_total = 16'd0;
`endif

endmodule
